cargador_instrucciones: RTL and testbench

- Program loader. It is the writer side of the instruction memory; the processor core is the reader.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words sequentially into the instruction memory write port.
- Holds the processor core in reset until a complete, valid image has been loaded.

---
 rtl/procesador_pkg.sv | 17 +
 rtl/ensamblador_palabra.sv | 52 +++++
 rtl/cargador_instrucciones.sv | 194 +++++++++++++++++++
 tb/tb_cargador_instrucciones.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/procesador_pkg.sv
// Shared constants for the instruction path: word/address widths and
// the program-loader state encoding.
package procesador_pkg;

    localparam int INSTR_W      = 32;
    localparam int INSTR_ADDR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_FIN   = 3'd5
    } estado_t;

endpackage

// File: rtl/ensamblador_palabra.sv
// Byte-to-word shift register: big-endian assembly, first byte ends up
// in the most significant lane. word_ready_o flags the final byte.
module ensamblador_palabra
    import procesador_pkg::*;
#(
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_ready_o
);

    localparam int         NB   = DATA_W / 8;
    localparam logic [1:0] LAST = 2'(NB - 1);

    logic [DATA_W-9:0] sh_q, sh_d;
    logic [1:0]        idx_q, idx_d;

    // The word is presented including the byte being accepted right now,
    // so the caller can latch it on the same edge.
    assign word_o       = {sh_q, byte_i};
    assign word_ready_o = accept_i && (idx_q == LAST);

    // Next shift contents and byte index; a stall simply holds both.
    always_comb begin
        sh_d  = sh_q;
        idx_d = idx_q;
        if (clear_i) begin
            sh_d  = '0;
            idx_d = '0;
        end else if (accept_i) begin
            sh_d  = {sh_q[DATA_W-17:0], byte_i};
            idx_d = (idx_q == LAST) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Shift register and byte index state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else begin
            sh_q  <= sh_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/cargador_instrucciones.sv
// Program loader: streams a length-prefixed byte image into instruction
// memory and holds the core in reset until it is complete.
// Optional trailing XOR check byte: define CARGADOR_CHECKSUM_EN.
module cargador_instrucciones
    import procesador_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = INSTR_ADDR_W,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iStart,
    input  logic [7:0]        iByte,
    input  logic              iValid,
    output logic              oReady,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError,
    output logic              oCpuReset,
    output logic [ADDR_W:0]   oCount
);

    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    estado_t           state_q;
    logic              rdy_q;
    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cpurst_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   n_q;

    logic              accept;
    logic              asm_accept;
    logic              asm_clear;
    logic [DATA_W-1:0] asm_word;
    logic              asm_ready;
    logic [ADDR_W:0]   cnt_inc;
    logic              n_big;

    assign accept     = iValid & rdy_q;
    assign asm_accept = accept & (state_q == ST_DATA);
    assign asm_clear  = iStart & (state_q == ST_IDLE);
    assign cnt_inc    = cnt_q + 1'b1;
    assign n_big      = {1'b0, iByte} > DEPTH_B;

    assign oReady    = rdy_q;
    assign oWrEn     = wren_q;
    assign oWrAddr   = addr_q;
    assign oWrData   = data_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oError    = err_q;
    assign oCpuReset = cpurst_q;
    assign oCount    = cnt_q;

    ensamblador_palabra #(
        .DATA_W (DATA_W)
    ) u_ens (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .accept_i     (asm_accept),
        .byte_i       (iByte),
        .word_o       (asm_word),
        .word_ready_o (asm_ready)
    );

`ifdef CARGADOR_CHECKSUM_EN
    logic [7:0] xor_q;

    // Running XOR of the data bytes; the length byte is not included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xor_q <= '0;
        end else if (asm_clear) begin
            xor_q <= '0;
        end else if (asm_accept) begin
            xor_q <= xor_q ^ iByte;
        end
    end
`endif

    // Session FSM with registered handshake, write port and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cpurst_q <= 1'b1;
            cnt_q    <= '0;
            n_q      <= '0;
        end else begin
            wren_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b0;
                    if (iStart) begin
                        state_q  <= ST_LEN;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        cpurst_q <= 1'b1;
                        cnt_q    <= '0;
                        addr_q   <= '0;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        n_q <= (ADDR_W+1)'(iByte);
                        if (iByte == 8'd0) begin
`ifdef CARGADOR_CHECKSUM_EN
                            state_q <= ST_CHECK;
`else
                            state_q <= ST_FIN;
                            rdy_q   <= 1'b0;
`endif
                        end else if (n_big) begin
                            state_q <= ST_IDLE;
                            rdy_q   <= 1'b0;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (asm_ready) begin
                        state_q <= ST_WRITE;
                        rdy_q   <= 1'b0;
                        wren_q  <= 1'b1;
                        data_q  <= asm_word;
                    end
                end
                ST_WRITE: begin
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_inc;
                    rdy_q  <= 1'b1;
                    if (cnt_inc == n_q) begin
`ifdef CARGADOR_CHECKSUM_EN
                        state_q <= ST_CHECK;
`else
                        state_q <= ST_FIN;
                        rdy_q   <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
`ifdef CARGADOR_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        rdy_q <= 1'b0;
                        if (iByte == xor_q) begin
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
`endif
                ST_FIN: begin
                    state_q  <= ST_IDLE;
                    rdy_q    <= 1'b0;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    cpurst_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Scoreboard bench for the program loader: expected memory writes are
// queued by the stimulus and consumed by an independent write monitor.
module tb_cargador_instrucciones;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iStart = 1'b0;
    logic [7:0]  iByte = 8'h00;
    logic        iValid = 1'b0;
    logic        oReady;
    logic        oWrEn;
    logic [5:0]  oWrAddr;
    logic [31:0] oWrData;
    logic        oBusy;
    logic        oDone;
    logic        oError;
    logic        oCpuReset;
    logic [6:0]  oCount;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    cargador_instrucciones dut (
        .clk       (clk),
        .reset     (reset),
        .iStart    (iStart),
        .iByte     (iByte),
        .iValid    (iValid),
        .oReady    (oReady),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oError    (oError),
        .oCpuReset (oCpuReset),
        .oCount    (oCount)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (oWrEn) begin
            chk("wr_ready_low", {63'd0, oReady}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", {58'd0, oWrAddr}, 64'h3f_ffff);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {58'd0, oWrAddr}, {58'd0, e.a});
                chk("wr_data", {32'd0, oWrData}, {32'd0, e.d});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int stall,
                             input bit pulse);
        bit ok;
        ok = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            iValid = 1'b0;
            iStart = 1'b0;
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            iStart = 1'b0;
            if (oReady) begin
                iValid = 1'b1;
                iByte  = b;
                iStart = pulse;
                ok     = 1'b1;
                break;
            end
            iValid = 1'b0;
        end
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        iValid = 1'b0;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            iValid = 1'b0;
            iStart = 1'b0;
            if (!oBusy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("busy_timeout", 64'd0, 64'd1);
    endtask

    // One session over the current img contents, with a length byte of n.
    task automatic load(input int n, input int stall, input bit bad_chk,
                        input bit busy_start);
        logic [7:0] x;
        bit         ok;
        int         k;
        x  = 8'h00;
        ok = (n <= 64);
        k  = 0;
`ifdef CARGADOR_CHECKSUM_EN
        if (bad_chk) ok = 1'b0;
`endif
        if (n <= 64)
            for (int i = 0; i < n; i++) exp_q.push_back({6'(i), img[i]});
        pulse_start();
        send_byte(8'(n), stall, 1'b0);
        if (n <= 64) begin
            for (int i = 0; i < n; i++)
                for (int j = 3; j >= 0; j--) begin
                    logic [31:0] w;
                    w = img[i];
                    x = x ^ w[j*8 +: 8];
                    send_byte(w[j*8 +: 8], stall, busy_start && k == 1);
                    k++;
                end
`ifdef CARGADOR_CHECKSUM_EN
            send_byte(bad_chk ? ~x : x, stall, 1'b0);
`endif
        end
        wait_idle();
        chk("done", {63'd0, oDone}, {63'd0, ok});
        chk("error", {63'd0, oError}, {63'd0, !ok});
        chk("cpu_reset", {63'd0, oCpuReset}, {63'd0, !ok});
        chk("count", {57'd0, oCount}, (n <= 64) ? 64'(n) : 64'd0);
        chk("writes_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", {63'd0, oReady}, 64'd0);
        chk("rst_wren", {63'd0, oWrEn}, 64'd0);
        chk("rst_busy", {63'd0, oBusy}, 64'd0);
        chk("rst_done", {63'd0, oDone}, 64'd0);
        chk("rst_error", {63'd0, oError}, 64'd0);
        chk("rst_addr", {58'd0, oWrAddr}, 64'd0);
        chk("rst_data", {32'd0, oWrData}, 64'd0);
        chk("rst_count", {57'd0, oCount}, 64'd0);
        chk("rst_cpu", {63'd0, oCpuReset}, 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b1;

        img = '{32'h20100005, 32'hAC220000};
        load(2, 0, 1'b0, 1'b0);
        load(2, 3, 1'b0, 1'b0);
        load(0, 0, 1'b0, 1'b0);
        load(65, 0, 1'b0, 1'b0);

        img = '{32'h20100005, 32'hAC220000};
        exp_q.push_back({6'd0, img[0]});
        pulse_start();
        send_byte(8'd2, 0, 1'b0);
        for (int j = 3; j >= 0; j--) begin
            logic [31:0] w;
            w = img[0];
            send_byte(w[j*8 +: 8], 0, 1'b0);
        end
        send_byte(8'hAC, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        @(negedge clk);
        iValid = 1'b0;
        reset  = 1'b0;
        #1;
        chk_reset_vals();
        chk("rst_writes_left", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        img = '{32'h00000000};
        load(1, 0, 1'b0, 1'b0);

        img = '{};
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        load(3, 1, 1'b0, 1'b1);

`ifdef CARGADOR_CHECKSUM_EN
        img = '{32'h12345678};
        load(1, 0, 1'b0, 1'b0);
        load(1, 0, 1'b1, 1'b0);
`endif

        for (int s = 0; s < 6; s++) begin
            int n;
            n = $urandom_range(1, 8);
            img = '{};
            for (int i = 0; i < n; i++) img.push_back($urandom);
            load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        img = '{};
        for (int i = 0; i < 64; i++) img.push_back($urandom);
        load(64, 0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
